// File: rtl/uart_msg_assembler.sv
// Receive-side framing: packs WORDS_PER_PACKET UART words (LSB first) into one
// message, splits header/payload, and discards partial messages after an idle timeout.
module uart_msg_assembler #(
  parameter int DATA_WIDTH   = 8,
  parameter int MSG_WIDTH    = 64,
  parameter int HEADER_WIDTH = 8,
  parameter int TIMEOUT_CLKS = 1_000_000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             byte_data,
  input  logic                              byte_valid,
  output logic [HEADER_WIDTH-1:0]           msg_header,
  output logic [MSG_WIDTH-HEADER_WIDTH-1:0] msg_payload,
  output logic                              msg_valid,
  input  logic                              msg_ready,
  output logic                              timeout_pulse,
  output logic                              overflow_pulse
);

  localparam int WPP    = MSG_WIDTH / DATA_WIDTH;
  localparam int CNT_W  = (WPP > 1) ? $clog2(WPP) : 1;
  localparam int IDLE_W = $clog2(TIMEOUT_CLKS);
  localparam logic [CNT_W-1:0]  LAST   = CNT_W'(WPP - 1);
  localparam logic [IDLE_W-1:0] EXPIRE = IDLE_W'(TIMEOUT_CLKS - 1);

  typedef enum logic {IDLE, ASSEMBLE} state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDLE_W-1:0]    idle, idle_n;
  logic [MSG_WIDTH-1:0] asm_buf, msg_next;
  logic                 complete, load, drop, expire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idle  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idle  <= idle_n;
    end
  end

  // A byte always wins over timeout expiry; the idle counter only runs mid-message.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idle_n  = idle;
    if (byte_valid) begin
      idle_n = '0;
      if (cnt == LAST) begin
        cnt_n   = '0;
        state_n = IDLE;
      end else begin
        cnt_n   = cnt + CNT_W'(1);
        state_n = ASSEMBLE;
      end
    end else if (state == ASSEMBLE) begin
      if (idle == EXPIRE) begin
        cnt_n   = '0;
        idle_n  = '0;
        state_n = IDLE;
      end else begin
        idle_n = idle + IDLE_W'(1);
      end
    end
  end

  always_comb begin
    msg_next = asm_buf;
    for (int w = 0; w < WPP; w++) begin
      if (cnt == CNT_W'(w)) msg_next[w*DATA_WIDTH +: DATA_WIDTH] = byte_data;
    end
    complete = byte_valid && (cnt == LAST);
    load     = complete && (!msg_valid || msg_ready);
    drop     = complete && msg_valid && !msg_ready;
    expire   = (state == ASSEMBLE) && !byte_valid && (idle == EXPIRE);
  end

  always_ff @(posedge clk) begin
    if (byte_valid) asm_buf <= msg_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      msg_valid      <= 1'b0;
      msg_header     <= '0;
      msg_payload    <= '0;
      timeout_pulse  <= 1'b0;
      overflow_pulse <= 1'b0;
    end else begin
      timeout_pulse  <= expire;
      overflow_pulse <= drop;
      if (load) begin
        msg_valid   <= 1'b1;
        msg_header  <= msg_next[HEADER_WIDTH-1:0];
        msg_payload <= msg_next[MSG_WIDTH-1:HEADER_WIDTH];
      end else if (msg_valid && msg_ready) begin
        msg_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_msg_assembler.sv
// Bench for uart_msg_assembler: directed scenarios plus random traffic, all
// compared against a queue-based message model.
module tb_uart_msg_assembler;
  localparam int TO  = 100;
  localparam int WPP = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_data = '0;
  logic        byte_valid = 1'b0;
  logic        msg_ready = 1'b0;
  logic [7:0]  msg_header;
  logic [55:0] msg_payload;
  logic        msg_valid, timeout_pulse, overflow_pulse;

  int compared = 0;
  int mismatched = 0;

  uart_msg_assembler #(.DATA_WIDTH(8), .MSG_WIDTH(64), .HEADER_WIDTH(8), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .rst(rst), .byte_data(byte_data), .byte_valid(byte_valid),
    .msg_header(msg_header), .msg_payload(msg_payload), .msg_valid(msg_valid),
    .msg_ready(msg_ready), .timeout_pulse(timeout_pulse), .overflow_pulse(overflow_pulse)
  );

  always #5 clk = ~clk;

  // Model: bytes of the message in progress, idle cycles since the last byte,
  // and the message currently offered to the consumer.
  logic [7:0]  part[$];
  int          gap = 0;
  logic        m_v = 1'b0;
  logic [63:0] m_msg = '0;
  logic        m_to = 1'b0, m_ov = 1'b0;

  wire [66:0] obs  = {msg_valid, msg_header, msg_payload, timeout_pulse, overflow_pulse};
  wire [66:0] expv = {m_v, m_msg[7:0], m_msg[63:8], m_to, m_ov};

  task automatic cycle(input logic bv, input logic [7:0] b, input logic rdy, input logic r);
    logic [63:0] m;
    logic        done;
    rst = r; byte_valid = bv; byte_data = b; msg_ready = rdy;
    m_to = 1'b0; m_ov = 1'b0; done = 1'b0; m = '0;
    if (r) begin
      part.delete(); gap = 0; m_v = 1'b0; m_msg = '0;
    end else begin
      if (bv) begin
        part.push_back(b);
        gap = 0;
        if (part.size() == WPP) begin
          foreach (part[i]) m = m | (64'(part[i]) << (8 * i));
          part.delete();
          done = 1'b1;
        end
      end else if (part.size() > 0) begin
        gap++;
        if (gap == TO) begin
          part.delete(); gap = 0; m_to = 1'b1;
        end
      end
      if (done) begin
        if (!m_v || rdy) begin m_v = 1'b1; m_msg = m; end
        else m_ov = 1'b1;
      end else if (m_v && rdy) begin
        m_v = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    compared++;
    if (obs !== 67'd0) begin
      mismatched++; $display("FAIL reset_values: got %h want 0", obs);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    compared++;
    if (obs !== expv) begin
      mismatched++; $display("FAIL reset_idle: got %h want %h", obs, expv);
    end
  endtask

  task automatic test_basic();
    int nv = 0, np = 0;
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 8'(i), 1'b1, 1'b0);
      compared++;
      if (obs !== expv) begin
        mismatched++; $display("FAIL basic_byte%0d: got %h want %h", i, obs, expv);
      end
      nv += int'(msg_valid); np += int'(timeout_pulse | overflow_pulse);
      if (i == 8) begin
        compared++;
        if ({msg_valid, msg_header, msg_payload} !== {1'b1, 8'h01, 56'h08070605040302}) begin
          mismatched++;
          $display("FAIL basic_msg: got v=%b h=%h p=%h want v=1 h=01 p=08070605040302",
                   msg_valid, msg_header, msg_payload);
        end
      end
      for (int g = 0; g < 10; g++) begin
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        nv += int'(msg_valid); np += int'(timeout_pulse | overflow_pulse);
      end
    end
    compared++;
    if (nv != 1 || np != 0) begin
      mismatched++; $display("FAIL basic_counts: got valid=%0d pulses=%0d want 1/0", nv, np);
    end
  endtask

  task automatic test_timeout();
    int when = -1, nv = 0;
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    cycle(1'b1, 8'hBB, 1'b1, 1'b0);
    cycle(1'b1, 8'hCC, 1'b1, 1'b0);
    for (int i = 1; i <= TO + 20; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      if (timeout_pulse && when < 0) when = i;
      nv += int'(msg_valid);
      compared++;
      if (obs !== expv) begin
        mismatched++; $display("FAIL timeout_cyc%0d: got %h want %h", i, obs, expv);
      end
    end
    compared++;
    if (when != TO || nv != 0) begin
      mismatched++; $display("FAIL timeout_when: got idle=%0d valid=%0d want %0d/0", when, nv, TO);
    end
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
    compared++;
    if ({msg_valid, msg_header, msg_payload} !== {1'b1, 8'h11, 56'h18171615141312}) begin
      mismatched++;
      $display("FAIL resync_msg: got v=%b h=%h p=%h want v=1 h=11 p=18171615141312",
               msg_valid, msg_header, msg_payload);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_expiry_boundary();
    int np = 0;
    for (int i = 1; i <= 3; i++) cycle(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
    for (int i = 1; i < TO; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      np += int'(timeout_pulse);
    end
    for (int i = 4; i <= 8; i++) begin
      cycle(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
      np += int'(timeout_pulse);
    end
    compared++;
    if (np != 0 || {msg_valid, msg_header, msg_payload} !== {1'b1, 8'h41, 56'h48474645444342}) begin
      mismatched++;
      $display("FAIL expiry_boundary: got to=%0d v=%b h=%h p=%h want to=0 v=1 h=41 p=48474645444342",
               np, msg_valid, msg_header, msg_payload);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    compared++;
    if ({overflow_pulse, msg_valid, msg_header, msg_payload} !== {2'b11, 8'h01, 56'h08070605040302}) begin
      mismatched++;
      $display("FAIL overflow: got ov=%b v=%b h=%h p=%h want ov=1 v=1 h=01 p=08070605040302",
               overflow_pulse, msg_valid, msg_header, msg_payload);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    compared++;
    if (obs !== expv || overflow_pulse !== 1'b0) begin
      mismatched++; $display("FAIL overflow_once: got %h want %h", obs, expv);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    compared++;
    if (msg_valid !== 1'b0 || obs !== expv) begin
      mismatched++; $display("FAIL drain: got %h want %h", obs, expv);
    end
  endtask

  task automatic test_handoff();
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 1; i <= 7; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h28, 1'b1, 1'b0);
    compared++;
    if ({overflow_pulse, msg_valid, msg_header, msg_payload} !== {2'b01, 8'h21, 56'h28272625242322}) begin
      mismatched++;
      $display("FAIL handoff: got ov=%b v=%b h=%h p=%h want ov=0 v=1 h=21 p=28272625242322",
               overflow_pulse, msg_valid, msg_header, msg_payload);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    compared++;
    if (obs !== expv || msg_valid !== 1'b0) begin
      mismatched++; $display("FAIL handoff_drain: got %h want %h", obs, expv);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    compared++;
    if (obs !== 67'd0) begin
      mismatched++; $display("FAIL reset_mid: got %h want 0", obs);
    end
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(8'h30 + i), 1'b1, 1'b0);
    compared++;
    if ({timeout_pulse, overflow_pulse, msg_valid, msg_header, msg_payload}
        !== {3'b001, 8'h31, 56'h38373635343332}) begin
      mismatched++;
      $display("FAIL reset_resume: got %h want v=1 h=31 p=38373635343332", obs);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int g;
    logic r;
    for (int n = 0; n < 400; n++) begin
      g = ($urandom_range(0, 19) == 0) ? int'($urandom_range(TO - 3, TO + 2)) : int'($urandom_range(0, 2));
      for (int k = 0; k < g; k++) begin
        cycle(1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'b0);
        compared++;
        if (obs !== expv) begin
          mismatched++; $display("FAIL random_idle n=%0d: got %h want %h", n, obs, expv);
        end
      end
      r = ($urandom_range(0, 149) == 0);
      cycle(1'b1, 8'($urandom), 1'($urandom_range(0, 1)), r);
      compared++;
      if (obs !== expv) begin
        mismatched++; $display("FAIL random_byte n=%0d: got %h want %h", n, obs, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_expiry_boundary();
    test_backpressure();
    test_handoff();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
